// File: rtl/matrix_input_loader.sv
// Row-major write sequencer feeding the matrix memory from a descriptor plus element stream.
// Optional feature: define MATRIX_LOADER_ZEROFILL_EN to pad the remaining elements with zeros on abort.
module matrix_input_loader #(
  parameter int DIM_W   = 3,
  parameter int ID_W    = 3,
  parameter int DATA_W  = 4,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ID_W-1:0]   cfg_id,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic              abort,
  input  logic              storage_full,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ID_W-1:0]   mem_matrix_id,
  output logic [DIM_W-1:0]  mem_rows,
  output logic [DIM_W-1:0]  mem_cols,
  output logic [DATA_W-1:0] mem_data,
  output logic [DIM_W-1:0]  mem_addr_row,
  output logic [DIM_W-1:0]  mem_addr_col,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [DIM_W-1:0] MAX_V = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

`ifdef MATRIX_LOADER_ZEROFILL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t state, next_state;

  logic [DIM_W-1:0] row_cnt, col_cnt;
  logic [DIM_W-1:0] last_row, last_col;
  logic             dims_ok, at_last, accept, step;

  assign dims_ok  = (cfg_rows != '0) && (cfg_rows <= MAX_V) &&
                    (cfg_cols != '0) && (cfg_cols <= MAX_V);
  assign last_row = mem_rows - ONE;
  assign last_col = mem_cols - ONE;
  assign at_last  = (row_cnt == last_row) && (col_cnt == last_col);
  assign accept   = (state == LOAD) && in_valid && !abort;

`ifdef MATRIX_LOADER_ZEROFILL_EN
  assign step = accept || (state == FILL);
`else
  assign step = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && dims_ok && !storage_full) next_state = LOAD;
      LOAD: begin
        if (abort) begin
`ifdef MATRIX_LOADER_ZEROFILL_EN
          next_state = FILL;
`else
          next_state = IDLE;
`endif
        end else if (in_valid && at_last) begin
          next_state = DONE;
        end
      end
`ifdef MATRIX_LOADER_ZEROFILL_EN
      FILL: if (at_last) next_state = DONE;
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = (state == LOAD) && !abort;
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // The counters park on the final position rather than wrapping past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt       <= '0;
      col_cnt       <= '0;
      mem_we        <= 1'b0;
      mem_matrix_id <= '0;
      mem_rows      <= '0;
      mem_cols      <= '0;
      mem_data      <= '0;
      mem_addr_row  <= '0;
      mem_addr_col  <= '0;
      err           <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      mem_we <= step;
      err    <= 1'b0;
      if (step) begin
        mem_data     <= accept ? in_data : '0;
        mem_addr_row <= row_cnt;
        mem_addr_col <= col_cnt;
        if (!at_last) begin
          if (col_cnt == last_col) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + ONE;
          end else begin
            col_cnt <= col_cnt + ONE;
          end
        end
      end
      if (state == IDLE && start) begin
        if (!dims_ok) begin
          err      <= 1'b1;
          err_code <= 2'd1;
        end else if (storage_full) begin
          err      <= 1'b1;
          err_code <= 2'd2;
        end else begin
          mem_matrix_id <= cfg_id;
          mem_rows      <= cfg_rows;
          mem_cols      <= cfg_cols;
          row_cnt       <= '0;
          col_cnt       <= '0;
        end
      end
`ifndef MATRIX_LOADER_ZEROFILL_EN
      if (state == LOAD && abort) begin
        err      <= 1'b1;
        err_code <= 2'd3;
      end
`endif
    end
  end

endmodule

// File: tb/tb_matrix_input_loader.sv
// Directed self-checking bench for matrix_input_loader; abort expectations follow MATRIX_LOADER_ZEROFILL_EN.
module tb_matrix_input_loader;

  logic       clk = 1'b0;
  logic       rst, start, abort, storage_full, in_valid;
  logic [2:0] cfg_id, cfg_rows, cfg_cols;
  logic [3:0] in_data;
  logic       in_ready, mem_we, busy, done, err;
  logic [2:0] mem_matrix_id, mem_rows, mem_cols, mem_addr_row, mem_addr_col;
  logic [3:0] mem_data;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  matrix_input_loader dut (
    .clk(clk), .rst(rst), .start(start), .cfg_id(cfg_id), .cfg_rows(cfg_rows),
    .cfg_cols(cfg_cols), .abort(abort), .storage_full(storage_full),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_matrix_id(mem_matrix_id), .mem_rows(mem_rows), .mem_cols(mem_cols),
    .mem_data(mem_data), .mem_addr_row(mem_addr_row), .mem_addr_col(mem_addr_col),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; storage_full = 1'b0; in_valid = 1'b0;
    cfg_id = '0; cfg_rows = '0; cfg_cols = '0; in_data = '0;
    tick(); tick();
    checks++;
    if ({in_ready, mem_we, busy, done, err, err_code, mem_matrix_id, mem_rows, mem_cols,
         mem_data, mem_addr_row, mem_addr_col} !== 30'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got nonzero outputs we=%b busy=%b code=%0d expected all 0",
               mem_we, busy, err_code);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle: busy=%b in_ready=%b expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic_load();
    start = 1'b1; cfg_id = 3'd2; cfg_rows = 3'd2; cfg_cols = 3'd3;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, in_ready, mem_we} !== 3'b110) begin
      errors++; $display("[TB] FAIL basic_start: busy/rdy/we=%b expected 110", {busy, in_ready, mem_we});
    end
    checks++;
    if ({mem_matrix_id, mem_rows, mem_cols} !== {3'd2, 3'd2, 3'd3}) begin
      errors++; $display("[TB] FAIL basic_latch: id=%0d rows=%0d cols=%0d expected 2 2 3",
                         mem_matrix_id, mem_rows, mem_cols);
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 1);
      tick();
      checks++;
      if ({mem_we, mem_data, mem_addr_row, mem_addr_col} !== {1'b1, 4'(i + 1), 3'(i / 3), 3'(i % 3)}) begin
        errors++;
        $display("[TB] FAIL basic_write[%0d]: we=%b data=%0d at (%0d,%0d) expected 1 %0d at (%0d,%0d)",
                 i, mem_we, mem_data, mem_addr_row, mem_addr_col, i + 1, i / 3, i % 3);
      end
      checks++;
      if (done !== (i == 5)) begin
        errors++; $display("[TB] FAIL basic_done[%0d]: got %b expected %b", i, done, i == 5);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({busy, done, mem_we} !== 3'b000) begin
      errors++; $display("[TB] FAIL basic_end: busy/done/we=%b expected 000", {busy, done, mem_we});
    end
  endtask

  task automatic test_bad_dims();
    start = 1'b1; cfg_id = 3'd7; cfg_rows = 3'd0; cfg_cols = 3'd3;
    tick();
    checks++;
    if ({err, err_code, busy, mem_we} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL dims_zero: err=%b code=%0d busy=%b we=%b expected 1 1 0 0",
                         err, err_code, busy, mem_we);
    end
    start = 1'b0;
    tick();
    checks++;
    if ({err, err_code} !== {1'b0, 2'd1}) begin
      errors++; $display("[TB] FAIL dims_hold: err=%b code=%0d expected 0 1", err, err_code);
    end
    start = 1'b1; cfg_rows = 3'd6; cfg_cols = 3'd1;
    tick();
    start = 1'b0;
    checks++;
    if ({err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL dims_six: err=%b code=%0d busy=%b expected 1 1 0", err, err_code, busy);
    end
    checks++;
    if ({mem_matrix_id, mem_rows, mem_cols} !== {3'd2, 3'd2, 3'd3}) begin
      errors++; $display("[TB] FAIL dims_stable: id=%0d rows=%0d cols=%0d expected 2 2 3",
                         mem_matrix_id, mem_rows, mem_cols);
    end
    tick();
  endtask

  task automatic test_storage_full();
    storage_full = 1'b1; start = 1'b1; cfg_rows = 3'd2; cfg_cols = 3'd2;
    tick();
    checks++;
    if ({err, err_code, busy} !== {1'b1, 2'd2, 1'b0}) begin
      errors++; $display("[TB] FAIL full_reject: err=%b code=%0d busy=%b expected 1 2 0", err, err_code, busy);
    end
    cfg_rows = 3'd0;
    tick();
    checks++;
    if ({err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL full_dims_prio: err=%b code=%0d busy=%b expected 1 1 0", err, err_code, busy);
    end
    start = 1'b0; storage_full = 1'b0;
    tick();
  endtask

  task automatic test_valid_gaps();
    int k = 0;
    int done_cnt = 0;
    start = 1'b1; cfg_id = 3'd5; cfg_rows = 3'd3; cfg_cols = 3'd3;
    tick();
    start = 1'b0;
    for (int c = 0; c < 18; c++) begin
      in_valid = (c % 2 == 0); in_data = 4'(k + 1);
      tick();
      if (done) done_cnt++;
      if (c % 2 == 0) begin
        checks++;
        if ({mem_we, mem_data, mem_addr_row, mem_addr_col} !== {1'b1, 4'(k + 1), 3'(k / 3), 3'(k % 3)}) begin
          errors++;
          $display("[TB] FAIL gap_write[%0d]: we=%b data=%0d at (%0d,%0d) expected 1 %0d at (%0d,%0d)",
                   k, mem_we, mem_data, mem_addr_row, mem_addr_col, k + 1, k / 3, k % 3);
        end
        k++;
      end else begin
        checks++;
        if (mem_we !== 1'b0) begin
          errors++; $display("[TB] FAIL gap_idle_we[%0d]: got %b expected 0", c, mem_we);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("[TB] FAIL gap_done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL gap_end_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; cfg_id = 3'd1; cfg_rows = 3'd2; cfg_cols = 3'd2;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 4'd7;
    tick();
    checks++;
    if ({mem_we, mem_data, mem_addr_row, mem_addr_col} !== {1'b1, 4'd7, 3'd0, 3'd0}) begin
      errors++; $display("[TB] FAIL abort_first: we=%b data=%0d at (%0d,%0d) expected 1 7 at (0,0)",
                         mem_we, mem_data, mem_addr_row, mem_addr_col);
    end
    abort = 1'b1; in_data = 4'd9;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_ready: got %b expected 0", in_ready);
    end
    tick();
    abort = 1'b0; in_valid = 1'b0;
`ifdef MATRIX_LOADER_ZEROFILL_EN
    checks++;
    if ({mem_we, err, busy} !== 3'b001) begin
      errors++; $display("[TB] FAIL fill_enter: we/err/busy=%b expected 001", {mem_we, err, busy});
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if ({mem_we, mem_data, mem_addr_row, mem_addr_col} !== {1'b1, 4'd0, 3'((j + 1) / 2), 3'((j + 1) % 2)}) begin
        errors++;
        $display("[TB] FAIL fill_write[%0d]: we=%b data=%0d at (%0d,%0d) expected 1 0 at (%0d,%0d)",
                 j, mem_we, mem_data, mem_addr_row, mem_addr_col, (j + 1) / 2, (j + 1) % 2);
      end
      checks++;
      if ({done, err} !== {(j == 2), 1'b0}) begin
        errors++; $display("[TB] FAIL fill_done[%0d]: done/err=%b expected %b0", j, {done, err}, j == 2);
      end
    end
    tick();
    checks++;
    if ({busy, mem_we, err_code} !== {1'b0, 1'b0, 2'd1}) begin
      errors++; $display("[TB] FAIL fill_end: busy=%b we=%b code=%0d expected 0 0 1", busy, mem_we, err_code);
    end
`else
    checks++;
    if ({err, err_code, mem_we, busy, done} !== {1'b1, 2'd3, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL abort_err: err=%b code=%0d we=%b busy=%b done=%b expected 1 3 0 0 0",
                         err, err_code, mem_we, busy, done);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if ({err, mem_we, done, err_code} !== {1'b0, 1'b0, 1'b0, 2'd3}) begin
        errors++; $display("[TB] FAIL abort_quiet[%0d]: err=%b we=%b done=%b code=%0d expected 0 0 0 3",
                           j, err, mem_we, done, err_code);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; cfg_id = 3'd3; cfg_rows = 3'd2; cfg_cols = 3'd2;
    tick();
    start = 1'b0; in_valid = 1'b1;
    in_data = 4'd1; tick();
    in_data = 4'd2; tick();
    in_data = 4'd5; rst = 1'b1;
    tick();
    checks++;
    if ({in_ready, mem_we, busy, done, err, err_code, mem_matrix_id, mem_rows, mem_cols,
         mem_data, mem_addr_row, mem_addr_col} !== 30'd0) begin
      errors++; $display("[TB] FAIL rst_mid: we=%b busy=%b id=%0d data=%0d expected all 0",
                         mem_we, busy, mem_matrix_id, mem_data);
    end
    rst = 1'b0; in_valid = 1'b0;
    start = 1'b1; cfg_id = 3'd4; cfg_rows = 3'd1; cfg_cols = 3'd1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, mem_matrix_id} !== {1'b1, 3'd4}) begin
      errors++; $display("[TB] FAIL rst_restart: busy=%b id=%0d expected 1 4", busy, mem_matrix_id);
    end
    in_valid = 1'b1; in_data = 4'hA;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({mem_we, mem_data, mem_addr_row, mem_addr_col, done} !== {1'b1, 4'hA, 3'd0, 3'd0, 1'b1}) begin
      errors++; $display("[TB] FAIL rst_single: we=%b data=%0h at (%0d,%0d) done=%b expected 1 a at (0,0) 1",
                         mem_we, mem_data, mem_addr_row, mem_addr_col, done);
    end
    tick();
    checks++;
    if ({busy, done, mem_we} !== 3'b000) begin
      errors++; $display("[TB] FAIL rst_single_end: busy/done/we=%b expected 000", {busy, done, mem_we});
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_dims();
    test_storage_full();
    test_valid_gaps();
    test_abort();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_input_loader.md
# matrix_input_loader

Upstream write sequencer for the matrix memory: accepts a matrix descriptor (ID, rows, cols) plus a stream of 4-bit elements and issues one row-major write per element on the memory write port. Validates dimensions, refuses to start when storage is full, and supports mid-load abort. Sits between the input parser (UART/switch front end) and the matrix memory.

## Interface
- DIM_W, 3: width of rows/cols/row/col address fields
- ID_W, 3: width of matrix ID
- DATA_W, 4: element width
- MAX_DIM, 5: largest legal rows/cols value
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  start request; sampled only in IDLE
- cfg_id  in  ID_W  target matrix ID
- cfg_rows  in  DIM_W  row count
- cfg_cols  in  DIM_W  column count
- abort  in  1  cancel current load
- storage_full  in  1  memory full flag
- in_valid  in  1  element valid
- in_data  in  DATA_W  element value
- in_ready  out  1  element accept; in_ready = (state==LOAD) && !abort
- mem_we  out  1  write strobe, registered
- mem_matrix_id  out  ID_W  latched cfg_id
- mem_rows  out  DIM_W  latched cfg_rows
- mem_cols  out  DIM_W  latched cfg_cols
- mem_data  out  DATA_W  write data, registered
- mem_addr_row  out  DIM_W  write row address, registered
- mem_addr_col  out  DIM_W  write column address, registered
- busy  out  1  high in LOAD, FILL, DONE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse
- err_code  out  2  last error: 0 none, 1 bad dims, 2 storage full, 3 aborted; held until next err

## Operation
- States: IDLE, LOAD, FILL, DONE.
- IDLE + start: cfg_rows or cfg_cols equal to 0 or greater than MAX_DIM -> err, err_code=1, stay IDLE. Else storage_full=1 -> err, err_code=2, stay IDLE. Dims check has priority. Otherwise latch cfg_id/rows/cols into mem_* fields, clear row/col counters, go LOAD.
- LOAD: element accepted when in_valid && in_ready. Accept captures in_data and current (row,col) into mem_data/mem_addr_*, asserts mem_we next cycle. Col increments; at cols-1 it wraps to 0 and row increments. Accept at (rows-1, cols-1) -> DONE.
- abort in LOAD: no element accepted that cycle (in_ready low); behaviour per Configuration.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE ignored; abort outside LOAD/FILL ignored.
- mem_matrix_id/rows/cols stay stable from latch until the next successful start.
- Counters never exceed rows-1/cols-1; no wrap past final element.

## Timing
- Reset: state IDLE, counters 0, all outputs 0 (in_ready, mem_we, mem_* fields, busy, done, err, err_code).
- Start accepted at cycle T: busy=1 and in_ready=1 from T+1.
- Element accepted at cycle T: mem_we=1 with its data/address at T+1; mem_we is 0 in any cycle not following an accept or fill step.
- Last element accepted at T: mem_we and done both 1 at T+1 (state DONE); busy=0, IDLE at T+2; new start accepted from T+2.
- Back-to-back accepts give one write per cycle; in_valid gaps produce no writes.
- err pulses the cycle after the rejected start or abort; err_code updates in the same cycle.
- rst mid-load: immediate return to IDLE next edge, pending write dropped, no done/err.

## Configuration
- MATRIX_LOADER_ZEROFILL_EN defined: abort in LOAD -> FILL. FILL writes data 0 at successive positions starting at the current counter, one per cycle (mem_we registered as in LOAD), in_ready=0; after writing (rows-1, cols-1) -> DONE, done pulses, no err. abort in FILL ignored.
- Not defined: abort in LOAD -> IDLE next cycle, err=1, err_code=3, no further writes, no done; FILL state absent.

## Test plan
- Reset, start id=2 rows=2 cols=3, 6 contiguous elements 1..6 -> six writes at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) data 1..6, id 2, done at cycle of 6th write, busy low one cycle later.
- start rows=0 cols=3, then rows=6 cols=1 -> err pulses, err_code=1, no writes, busy stays 0.
- storage_full=1, start rows=2 cols=2 -> err, err_code=2; same with rows=0 -> err_code=1.
- rows=3 cols=3, in_valid toggling every other cycle -> nine writes in row-major order, mem_we only after accepts, done once.
- rows=2 cols=2, abort with in_valid=1 after 1 element -> without macro: one write, err_code=3, no done; with MATRIX_LOADER_ZEROFILL_EN: writes of 0 at (0,1),(1,0),(1,1) on consecutive cycles, done, err stays 0.
- rst asserted mid-LOAD after 2 elements -> next cycle all outputs 0, new start accepted and completes normally.
